hp_manager: RTL and testbench
=============================

HP_MANAGER -- requirements
Module: hp_manager

Interface
REQ-001 TOTAL_HP, 20, starting and maximum HP per player.
REQ-002 DMG_W, 5, width of a damage amount.
REQ-003 INVULN_FRAMES, 30, frames a player ignores further hits after an accepted hit.
REQ-004 KO_HOLD_FRAMES, 120, frames spent in KO_HOLD before OVER.
REQ-005 Clk  in  1  single system clock; all state on rising edge.
REQ-006 Reset  in  1  asynchronous, active-low reset.
REQ-007 frame_clk  in  1  vertical-sync level, asynchronous to Clk.
REQ-008 round_start  in  1  one-Clk pulse; starts or restarts a round from any state.
REQ-009 hit1 / hit2  in  1  one-Clk pulse: player 1 / player 2 struck.
REQ-010 dmg1 / dmg2  in  DMG_W  damage for the matching hit; valid only with its pulse.
REQ-011 hp1 / hp2  out  19  committed HP, zero-extended, range 0..TOTAL_HP; feeds the HP-bar renderer.
REQ-012 exist_hp  out  1  high in FIGHT, KO_HOLD and OVER.
REQ-013 ko  out  1  high in KO_HOLD and OVER.
REQ-014 winner  out  2  00 none, 01 P1 wins, 10 P2 wins, 11 draw.
REQ-015 round_over  out  1  high only in OVER.

Function
REQ-016 frame_clk SHALL pass through a 2-flop synchronizer and rising-edge detector, giving frame_tick, a one-Clk pulse asserted exactly 3 Clk edges after the frame_clk rise.
REQ-017 States SHALL be IDLE, FIGHT, KO_HOLD and OVER; round_start in any state → FIGHT, hp1=hp2=TOTAL_HP, pending=0, invuln=0, winner=00, hold counter=0.
REQ-018 In FIGHT, a hit with invuln counter 0 SHALL be accepted: add dmg to that player's pending damage (saturating at TOTAL_HP) and load its invuln counter with INVULN_FRAMES; hits with counter ≠0 or outside FIGHT SHALL be ignored.
REQ-019 Each invuln counter SHALL decrement by 1 per frame_tick while nonzero, in every state.
REQ-020 On frame_tick in FIGHT, hpN SHALL become max(hpN − pendingN, 0) and pendingN SHALL clear; hp outputs SHALL change at no other time (no mid-frame tearing).
REQ-021 A hit accepted in the same cycle as frame_tick SHALL NOT affect this commit; pending SHALL become exactly that dmg.
REQ-022 A dmg of 0 SHALL still be accepted and start invulnerability.
REQ-023 The cycle after a commit leaves either HP at 0, FIGHT → KO_HOLD with winner = 01 if only hp2=0, 10 if only hp1=0, 11 if both.
REQ-024 KO_HOLD SHALL count frame_ticks; on the KO_HOLD_FRAMES-th tick → OVER. OVER holds until round_start.
REQ-025 round_start coincident with a hit or frame_tick SHALL win: the round is reinitialised, and that hit and tick are discarded.
REQ-026 Pending damage SHALL be DMG_W+1 bits internally; subtraction SHALL NOT wrap.

Reset
REQ-027 Reset low SHALL immediately force IDLE, hp1=hp2=TOTAL_HP, pending=0, invuln=0, hold counter=0, synchronizer flops=0, exist_hp=0, ko=0, winner=00, round_over=0.
REQ-028 Reset asserted mid-round SHALL discard all pending damage; after release, no frame_tick SHALL be produced until a fresh frame_clk rise.

Structure
REQ-029 Package hp_pkg SHALL hold TOTAL_HP, DMG_W, INVULN_FRAMES, KO_HOLD_FRAMES defaults, the state enum, and the winner encoding constants.
REQ-030 Sub-module frame_tick_gen SHALL contain the synchronizer and edge detector.

Verification
REQ-031 Reset, round_start, hit1 dmg1=5, one frame_clk rise → hp1 stays 20 until frame_tick, then 15; hp2=20.
REQ-032 hit2 dmg=4 accepted, hit2 dmg=9 two frames later → second ignored; hp2=16 after commit; third hit after 30 ticks is accepted.
REQ-033 hp1=3, hit1 dmg=31 → hp1=0 at next tick, then ko=1, winner=10; after 120 ticks round_over=1.
REQ-034 hp1=hp2=2, both hits dmg=2 in one frame → both 0 at same tick, winner=11.
REQ-035 hit1 same cycle as frame_tick → no change this tick; hp1 drops by dmg at next tick.
REQ-036 Reset low mid-KO_HOLD → all outputs at reset values asynchronously; round_start afterwards → FIGHT, hp=20/20.

Source files
------------

// File: rtl/hp_pkg.sv
// Shared constants, state encoding and damage arithmetic for the HP manager.
package hp_pkg;

  localparam int unsigned TOTAL_HP       = 20;
  localparam int unsigned DMG_W          = 5;
  localparam int unsigned INVULN_FRAMES  = 30;
  localparam int unsigned KO_HOLD_FRAMES = 120;

  localparam int unsigned HP_OUT_W = 19;
  localparam int unsigned HP_W     = 5;
  localparam int unsigned PEND_W   = DMG_W + 1;
  localparam int unsigned INV_W    = 5;
  localparam int unsigned HOLD_W   = 7;
  localparam int unsigned WIN_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIGHT,
    ST_KO_HOLD,
    ST_OVER
  } hp_state_e;

  localparam logic [WIN_W-1:0] WIN_NONE = 2'b00;
  localparam logic [WIN_W-1:0] WIN_P1   = 2'b01;
  localparam logic [WIN_W-1:0] WIN_P2   = 2'b10;
  localparam logic [WIN_W-1:0] WIN_DRAW = 2'b11;

  // Accumulate a hit into pending damage, clamped at a full HP bar.
  function automatic logic [PEND_W-1:0] sat_add(input logic [PEND_W-1:0] pend,
                                                input logic [DMG_W-1:0]  dmg);
    logic [PEND_W-1:0] sum;
    sum = pend + PEND_W'(dmg);
    if (sum > PEND_W'(TOTAL_HP)) return PEND_W'(TOTAL_HP);
    return sum;
  endfunction

  // Apply pending damage to HP, flooring at zero instead of wrapping.
  function automatic logic [HP_W-1:0] commit_hp(input logic [HP_W-1:0]   hp,
                                                 input logic [PEND_W-1:0] pend);
    if (pend >= PEND_W'(hp)) return '0;
    return HP_W'(PEND_W'(hp) - pend);
  endfunction

endpackage

// File: rtl/hp_manager_if.sv
// Round control, hit inputs and HP/round status outputs of the HP manager.
interface hp_manager_if;
  import hp_pkg::*;

  logic                round_start;
  logic                hit1;
  logic                hit2;
  logic [DMG_W-1:0]    dmg1;
  logic [DMG_W-1:0]    dmg2;
  logic [HP_OUT_W-1:0] hp1;
  logic [HP_OUT_W-1:0] hp2;
  logic                exist_hp;
  logic                ko;
  logic [WIN_W-1:0]    winner;
  logic                round_over;

  modport master (
    output round_start, hit1, hit2, dmg1, dmg2,
    input  hp1, hp2, exist_hp, ko, winner, round_over
  );

  modport slave (
    input  round_start, hit1, hit2, dmg1, dmg2,
    output hp1, hp2, exist_hp, ko, winner, round_over
  );

endinterface

// File: rtl/frame_tick_gen.sv
// Brings the vsync level into the Clk domain and emits a one-cycle tick per rise.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic frame_tick
);

  logic sync1;
  logic sync2;
  logic sync_prev;
  logic sync_valid;
  logic armed;

  // Synchronizer, edge detector and arm flag; a level already high at reset
  // release must be seen low once before any rise can produce a tick.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync_prev  <= 1'b0;
      sync_valid <= 1'b0;
      armed      <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      sync1      <= frame_clk;
      sync2      <= sync1;
      sync_prev  <= sync2;
      sync_valid <= 1'b1;
      armed      <= armed | (sync_valid & ~sync1);
      frame_tick <= sync2 & ~sync_prev & armed;
    end
  end

endmodule

// File: rtl/hp_manager.sv
// Two-player HP bookkeeping: buffered damage, invulnerability windows,
// frame-aligned HP commits and KO/round-over sequencing.
module hp_manager
  import hp_pkg::*;
(
  input  logic         Clk,
  input  logic         Reset,
  input  logic         frame_clk,
  hp_manager_if.slave  bus
);

  logic frame_tick;

  hp_state_e          state_q,  state_d;
  logic [HP_W-1:0]    hp1_q,    hp1_d;
  logic [HP_W-1:0]    hp2_q,    hp2_d;
  logic [PEND_W-1:0]  pend1_q,  pend1_d;
  logic [PEND_W-1:0]  pend2_q,  pend2_d;
  logic [INV_W-1:0]   inv1_q,   inv1_d;
  logic [INV_W-1:0]   inv2_q,   inv2_d;
  logic [HOLD_W-1:0]  hold_q,   hold_d;
  logic [WIN_W-1:0]   winner_q, winner_d;
  logic               exist_q,  exist_d;
  logic               ko_q,     ko_d;
  logic               over_q,   over_d;

  frame_tick_gen u_frame_tick_gen (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .frame_tick (frame_tick)
  );

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      hp1_q    <= HP_W'(TOTAL_HP);
      hp2_q    <= HP_W'(TOTAL_HP);
      pend1_q  <= '0;
      pend2_q  <= '0;
      inv1_q   <= '0;
      inv2_q   <= '0;
      hold_q   <= '0;
      winner_q <= WIN_NONE;
      exist_q  <= 1'b0;
      ko_q     <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hp1_q    <= hp1_d;
      hp2_q    <= hp2_d;
      pend1_q  <= pend1_d;
      pend2_q  <= pend2_d;
      inv1_q   <= inv1_d;
      inv2_q   <= inv2_d;
      hold_q   <= hold_d;
      winner_q <= winner_d;
      exist_q  <= exist_d;
      ko_q     <= ko_d;
      over_q   <= over_d;
    end
  end

  // Next-state: round restart dominates; otherwise hits, frame commits and KO timing.
  always_comb begin
    state_d  = state_q;
    hp1_d    = hp1_q;
    hp2_d    = hp2_q;
    pend1_d  = pend1_q;
    pend2_d  = pend2_q;
    inv1_d   = inv1_q;
    inv2_d   = inv2_q;
    hold_d   = hold_q;
    winner_d = winner_q;

    if (bus.round_start) begin
      state_d  = ST_FIGHT;
      hp1_d    = HP_W'(TOTAL_HP);
      hp2_d    = HP_W'(TOTAL_HP);
      pend1_d  = '0;
      pend2_d  = '0;
      inv1_d   = '0;
      inv2_d   = '0;
      hold_d   = '0;
      winner_d = WIN_NONE;
    end else begin
      if (frame_tick) begin
        if (inv1_q != '0) inv1_d = inv1_q - 1'b1;
        if (inv2_q != '0) inv2_d = inv2_q - 1'b1;
      end

      unique case (state_q)
        ST_FIGHT: begin
          if (frame_tick) begin
            hp1_d   = commit_hp(hp1_q, pend1_q);
            hp2_d   = commit_hp(hp2_q, pend2_q);
            pend1_d = '0;
            pend2_d = '0;
          end
          // A hit landing on the commit tick starts a fresh pending total.
          if (bus.hit1 && (inv1_q == '0)) begin
            pend1_d = sat_add(frame_tick ? PEND_W'(0) : pend1_q, bus.dmg1);
            inv1_d  = INV_W'(INVULN_FRAMES);
          end
          if (bus.hit2 && (inv2_q == '0)) begin
            pend2_d = sat_add(frame_tick ? PEND_W'(0) : pend2_q, bus.dmg2);
            inv2_d  = INV_W'(INVULN_FRAMES);
          end
          if ((hp1_q == '0) || (hp2_q == '0)) begin
            state_d = ST_KO_HOLD;
            if ((hp1_q == '0) && (hp2_q == '0)) winner_d = WIN_DRAW;
            else if (hp2_q == '0)               winner_d = WIN_P1;
            else                                winner_d = WIN_P2;
          end
        end
        ST_KO_HOLD: begin
          if (frame_tick) begin
            hold_d = hold_q + 1'b1;
            if (hold_q == HOLD_W'(KO_HOLD_FRAMES - 1)) state_d = ST_OVER;
          end
        end
        default: begin
        end
      endcase
    end

    exist_d = (state_d != ST_IDLE);
    ko_d    = (state_d == ST_KO_HOLD) || (state_d == ST_OVER);
    over_d  = (state_d == ST_OVER);
  end

  assign bus.hp1        = HP_OUT_W'(hp1_q);
  assign bus.hp2        = HP_OUT_W'(hp2_q);
  assign bus.exist_hp   = exist_q;
  assign bus.ko         = ko_q;
  assign bus.winner     = winner_q;
  assign bus.round_over = over_q;

endmodule

// File: tb/tb_hp_manager.sv
// Directed bench for hp_manager with a per-cycle behavioural reference.
module tb_hp_manager;

  localparam int FULL   = 20;
  localparam int INVUL  = 30;
  localparam int HOLD   = 120;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic frame_clk = 1'b0;

  hp_manager_if bus();

  hp_manager dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .bus       (bus)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain game rules, one update per rising Clk edge.
  int m_st = 0;              // 0 idle, 1 fight, 2 ko hold, 3 over
  int m_hp1 = FULL, m_hp2 = FULL;
  int m_pend1 = 0, m_pend2 = 0;
  int m_inv1 = 0, m_inv2 = 0;
  int m_hold = 0, m_win = 0;
  int m_tick_in = 0;
  bit m_fc_prev = 0, m_fc_armed = 0, m_tick = 0;
  int o_hp1, o_hp2, o_inv1, o_inv2;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_st = 0; m_hp1 = FULL; m_hp2 = FULL; m_pend1 = 0; m_pend2 = 0;
      m_inv1 = 0; m_inv2 = 0; m_hold = 0; m_win = 0;
      m_tick_in = 0; m_fc_prev = 0; m_fc_armed = 0;
    end else begin
      // frame_tick is consumed on the 4th rising edge counting the one that first sees the rise
      m_tick = 0;
      if (m_tick_in > 0) begin
        m_tick_in--;
        if (m_tick_in == 0) m_tick = 1;
      end
      if (frame_clk && !m_fc_prev && m_fc_armed) m_tick_in = 3;
      if (!frame_clk) m_fc_armed = 1;
      m_fc_prev = frame_clk;

      if (bus.round_start) begin
        m_st = 1; m_hp1 = FULL; m_hp2 = FULL; m_pend1 = 0; m_pend2 = 0;
        m_inv1 = 0; m_inv2 = 0; m_hold = 0; m_win = 0;
      end else begin
        o_hp1 = m_hp1; o_hp2 = m_hp2; o_inv1 = m_inv1; o_inv2 = m_inv2;
        if (m_tick) begin
          if (m_inv1 > 0) m_inv1--;
          if (m_inv2 > 0) m_inv2--;
        end
        if (m_st == 1) begin
          if (m_tick) begin
            m_hp1 = (o_hp1 > m_pend1) ? o_hp1 - m_pend1 : 0;
            m_hp2 = (o_hp2 > m_pend2) ? o_hp2 - m_pend2 : 0;
            m_pend1 = 0; m_pend2 = 0;
          end
          if (bus.hit1 && o_inv1 == 0) begin
            m_pend1 = (m_pend1 + int'(bus.dmg1) > FULL) ? FULL : m_pend1 + int'(bus.dmg1);
            m_inv1 = INVUL;
          end
          if (bus.hit2 && o_inv2 == 0) begin
            m_pend2 = (m_pend2 + int'(bus.dmg2) > FULL) ? FULL : m_pend2 + int'(bus.dmg2);
            m_inv2 = INVUL;
          end
          if (o_hp1 == 0 || o_hp2 == 0) begin
            m_st = 2;
            m_win = (o_hp1 == 0 && o_hp2 == 0) ? 3 : (o_hp2 == 0 ? 1 : 2);
          end
        end else if (m_st == 2) begin
          if (m_tick) begin
            m_hold++;
            if (m_hold == HOLD) m_st = 3;
          end
        end
      end
    end
  end

  // Compare DUT outputs against the model away from the active edge.
  always @(negedge Clk) begin
    chk("model_hp1",        int'(bus.hp1),        m_hp1);
    chk("model_hp2",        int'(bus.hp2),        m_hp2);
    chk("model_exist_hp",   int'(bus.exist_hp),   (m_st != 0) ? 1 : 0);
    chk("model_ko",         int'(bus.ko),         (m_st >= 2) ? 1 : 0);
    chk("model_winner",     int'(bus.winner),     m_win);
    chk("model_round_over", int'(bus.round_over), (m_st == 3) ? 1 : 0);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic start_round();
    bus.round_start = 1'b1;
    cyc(1);
    bus.round_start = 1'b0;
  endtask

  task automatic hit_both(input int d1, input int d2, input bit h1, input bit h2);
    bus.hit1 = h1; bus.dmg1 = 5'(d1);
    bus.hit2 = h2; bus.dmg2 = 5'(d2);
    cyc(1);
    bus.hit1 = 1'b0; bus.dmg1 = '0;
    bus.hit2 = 1'b0; bus.dmg2 = '0;
  endtask

  task automatic hit(input int p, input int d);
    if (p == 1) hit_both(d, 0, 1'b1, 1'b0);
    else        hit_both(0, d, 1'b0, 1'b1);
  endtask

  task automatic frame();
    frame_clk = 1'b1;
    cyc(4);
    frame_clk = 1'b0;
    cyc(4);
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hp1"},        int'(bus.hp1),        20);
    chk({tag, "_hp2"},        int'(bus.hp2),        20);
    chk({tag, "_exist_hp"},   int'(bus.exist_hp),   0);
    chk({tag, "_ko"},         int'(bus.ko),         0);
    chk({tag, "_winner"},     int'(bus.winner),     0);
    chk({tag, "_round_over"}, int'(bus.round_over), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.round_start = 1'b0;
    bus.hit1 = 1'b0; bus.hit2 = 1'b0;
    bus.dmg1 = '0;   bus.dmg2 = '0;

    // Reset and idle
    cyc(3);
    chk_reset_vals("reset");
    Reset = 1'b1;
    cyc(3);
    chk("idle_exist_hp", int'(bus.exist_hp), 0);
    start_round();
    chk("start_exist_hp", int'(bus.exist_hp), 1);
    chk("start_hp1", int'(bus.hp1), 20);

    // Single hit, HP holds until the frame tick
    hit(1, 5);
    frame_clk = 1'b1;
    cyc(3);
    chk("hit5_hp1_before_tick", int'(bus.hp1), 20);
    cyc(1);
    chk("hit5_hp1_after_tick", int'(bus.hp1), 15);
    chk("hit5_hp2", int'(bus.hp2), 20);
    frame_clk = 1'b0;
    cyc(4);

    // Invulnerability window on player 2
    hit(2, 4);
    frame();
    chk("inv_first_hp2", int'(bus.hp2), 16);
    frame();
    hit(2, 9);
    frame();
    chk("inv_second_ignored_hp2", int'(bus.hp2), 16);
    frames(26);
    hit(2, 2);
    frame();
    chk("inv_29_ticks_ignored_hp2", int'(bus.hp2), 16);
    hit(2, 1);
    frame();
    chk("inv_after_30_ticks_hp2", int'(bus.hp2), 15);
    chk("inv_hp1_untouched", int'(bus.hp1), 15);

    // Overkill on player 1, KO hold and round over
    start_round();
    hit(1, 17);
    frame();
    chk("ko_setup_hp1", int'(bus.hp1), 3);
    frames(29);
    hit(1, 31);
    frame();
    chk("ko_hp1_zero", int'(bus.hp1), 0);
    chk("ko_flag", int'(bus.ko), 1);
    chk("ko_winner_p2", int'(bus.winner), 2);
    chk("ko_not_over", int'(bus.round_over), 0);
    frames(119);
    chk("ko_119_not_over", int'(bus.round_over), 0);
    frame();
    chk("ko_120_over", int'(bus.round_over), 1);
    hit(2, 5);
    frame();
    chk("over_hp2_frozen", int'(bus.hp2), 20);
    chk("over_holds", int'(bus.round_over), 1);

    // Double KO
    start_round();
    hit_both(18, 18, 1'b1, 1'b1);
    frame();
    chk("draw_setup_hp1", int'(bus.hp1), 2);
    chk("draw_setup_hp2", int'(bus.hp2), 2);
    frames(29);
    hit_both(2, 2, 1'b1, 1'b1);
    frame();
    chk("draw_hp1", int'(bus.hp1), 0);
    chk("draw_hp2", int'(bus.hp2), 0);
    chk("draw_winner", int'(bus.winner), 3);

    // round_start beats a coincident hit
    bus.round_start = 1'b1; bus.hit1 = 1'b1; bus.dmg1 = 5'd5;
    cyc(1);
    bus.round_start = 1'b0; bus.hit1 = 1'b0; bus.dmg1 = '0;
    frame();
    chk("start_vs_hit_hp1", int'(bus.hp1), 20);

    // round_start beats a coincident tick; pending damage is dropped
    hit(1, 5);
    frame_clk = 1'b1;
    cyc(3);
    start_round();
    frame_clk = 1'b0;
    cyc(4);
    frame();
    chk("start_vs_tick_hp1", int'(bus.hp1), 20);

    // Zero damage still opens an invulnerability window
    hit(2, 0);
    hit(2, 5);
    frame();
    chk("dmg0_blocks_hp2", int'(bus.hp2), 20);

    // Hit on the commit tick lands on the following tick
    frame_clk = 1'b1;
    cyc(3);
    hit(1, 7);
    chk("hit_on_tick_hp1_now", int'(bus.hp1), 20);
    frame_clk = 1'b0;
    cyc(4);
    frame();
    chk("hit_on_tick_hp1_next", int'(bus.hp1), 13);

    // Asynchronous reset during KO hold
    start_round();
    hit(2, 31);
    frame();
    chk("ko2_winner_p1", int'(bus.winner), 1);
    frames(2);
    @(posedge Clk);
    #2;
    Reset = 1'b0;
    frame_clk = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    cyc(3);
    Reset = 1'b1;
    start_round();
    chk("post_reset_exist_hp", int'(bus.exist_hp), 1);
    chk("post_reset_hp2", int'(bus.hp2), 20);
    hit(1, 5);
    cyc(6);
    chk("no_tick_from_held_level_hp1", int'(bus.hp1), 20);
    frame_clk = 1'b0;
    cyc(4);
    frame();
    chk("fresh_rise_hp1", int'(bus.hp1), 15);

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
